// File: rtl/data_memory_hs.sv
// data_memory_hs: word-organised data memory with a valid/ready request port
// and a valid/ready response port. After reset it clears itself one word per
// cycle, then serves one request at a time. The response appears READ_LATENCY
// cycles after the accepting edge.
module data_memory_hs #(
  parameter int MEM_DEPTH    = 2048,  // 32-bit words, power of two, 4..65536
  parameter int READ_LATENCY = 1      // accept-to-response cycles, 1..4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        init_busy
);

  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [AW-1:0]   init_idx;
  logic [1:0]      wait_cnt;
  logic [31:0]     mem [MEM_DEPTH];

  logic            accept;
  logic            addr_err;
  logic            init_last;
  logic            wait_done;
  logic [AW-1:0]   word_idx;

  // A request is taken only in IDLE; reset suppresses it so a discarded
  // transaction leaves no trace.
  assign accept    = !reset && (state == IDLE) && req_valid;
  assign addr_err  = (req_addr[1:0] != 2'b00) ||
                     ({2'b00, req_addr[31:2]} >= 32'(MEM_DEPTH));
  assign word_idx  = req_addr[AW+1:2];
  assign init_last = (init_idx == AW'(MEM_DEPTH - 1));
  // With READ_LATENCY=1 WAIT is never entered, so this compare is unused then.
  assign wait_done = (wait_cnt == 2'(READ_LATENCY - 2));

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign init_busy  = (state == INIT);

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) state <= INIT;
    else       state <= state_next;
  end

  // Next-state logic for clear, idle, latency wait and response hold.
  always_comb begin
    // NOTE: default assigned first so no path through the case infers a latch.
    state_next = state;
    unique case (state)
      INIT: if (init_last)  state_next = IDLE;
      IDLE: if (accept)     state_next = (READ_LATENCY > 1) ? WAIT : RESP;
      WAIT: if (wait_done)  state_next = RESP;
      RESP: if (resp_ready) state_next = IDLE;
      default:              state_next = INIT;
    endcase
  end

  // Clear-sequence word index; wraps back to 0 once the last word is written.
  always_ff @(posedge clock) begin
    if (reset)               init_idx <= '0;
    else if (state == INIT)  init_idx <= init_idx + 1'b1;
  end

  // Latency counter: restarts on every accept, advances while in WAIT.
  always_ff @(posedge clock) begin
    if (reset || accept)     wait_cnt <= '0;
    else if (state == WAIT)  wait_cnt <= wait_cnt + 1'b1;
  end

  // Response registers are loaded once at the accepting edge and then held,
  // which keeps them stable for as long as the consumer stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      resp_err   <= addr_err;
      resp_rdata <= (!addr_err && !req_wen) ? mem[word_idx] : 32'h0;
    end
  end

  // Storage: zero-fill during INIT, byte-masked writes on accepted requests.
  always_ff @(posedge clock) begin
    // NOTE: the array has no reset branch; clearing is done by the INIT
    // sequence so the memory can map onto block RAM.
    if (state == INIT) begin
      mem[init_idx] <= 32'h0;
    end else if (accept && req_wen && !addr_err) begin
      for (int k = 0; k < 4; k++) begin
        if (req_be[k]) mem[word_idx][8*k +: 8] <= req_wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: doc/data_memory_hs.md
DATA_MEMORY_HS -- requirements
Module: data_memory_hs

Interface
REQ-001 Parameter MEM_DEPTH, default 2048, number of 32-bit words; SHALL be a power of two, 4..65536.
REQ-002 Parameter READ_LATENCY, default 1, accept-to-response cycles; SHALL be 1..4.
REQ-003 clock  in  1  sole clock; all state SHALL update on posedge clock only.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  block can accept a request this cycle.
REQ-007 req_addr  in  32  byte address.
REQ-008 req_wen  in  1  1 = write, 0 = read.
REQ-009 req_be  in  4  write byte enables; bit k gates wdata[8k+7:8k]; ignored on reads.
REQ-010 req_wdata  in  32  write data.
REQ-011 resp_valid  out  1  response present.
REQ-012 resp_ready  in  1  consumer accepts response.
REQ-013 resp_rdata  out  32  read word; 0 for writes and errors.
REQ-014 resp_err  out  1  request was misaligned or out of range.
REQ-015 init_busy  out  1  memory clear in progress.

Function
REQ-016 FSM states SHALL be INIT, IDLE, WAIT, RESP.
REQ-017 INIT: one word per cycle SHALL be written to 0, index 0..MEM_DEPTH-1; after index MEM_DEPTH-1 is written -> IDLE; init_busy=1 only in INIT.
REQ-018 req_ready SHALL be 1 exactly in IDLE; a request is accepted on a posedge with req_valid && req_ready.
REQ-019 Accept in IDLE -> WAIT if READ_LATENCY>1, else -> RESP; WAIT SHALL count READ_LATENCY-1 cycles, then -> RESP.
REQ-020 resp_valid SHALL be 1 exactly in RESP; first asserted READ_LATENCY cycles after the accepting edge.
REQ-021 RESP with resp_ready=1 -> IDLE on that edge; resp_ready=0 holds RESP; resp_rdata and resp_err SHALL stay stable while held.
REQ-022 Only one request SHALL be outstanding; no new request is accepted until the response handshake completes.
REQ-023 Address, wen, be and wdata SHALL be captured at the accepting edge; later input changes do not affect the transaction.
REQ-024 Error iff req_addr[1:0]!=0 or req_addr[31:2] >= MEM_DEPTH; the error response SHALL have resp_err=1 and resp_rdata=0, and memory is unchanged.
REQ-025 Valid write: bytes with be[k]=1 SHALL be updated at the accepting edge; other bytes kept; response carries rdata=0, err=0.
REQ-026 Valid read: resp_rdata SHALL be the word at addr[31:2] as of the accepting edge, including any write whose response completed earlier.
REQ-027 Write with be=4'b0000 SHALL change no data and SHALL still produce a normal response.
REQ-028 Requests arriving during INIT SHALL be ignored (req_ready=0) and SHALL not be queued.

Reset
REQ-029 reset=1 at a posedge SHALL force INIT at index 0, discard any in-flight transaction, and give resp_valid=0, req_ready=0, init_busy=1, resp_rdata=0, resp_err=0 from the next cycle.
REQ-030 Reset SHALL override every other input in the same cycle, including a completing handshake.
REQ-031 After reset deasserts, IDLE (req_ready=1) SHALL be reached exactly MEM_DEPTH cycles later, with every word equal to 0.

Verification
REQ-032 MEM_DEPTH=16: reset, release -> init_busy=1 for 16 cycles, then req_ready=1; read addr 0x3C -> rdata 0x00000000, err=0.
REQ-033 LAT=3: write 0x8 wdata 0xDEADBEEF be=1111; read 0x8 -> resp_valid exactly 3 cycles after accept, rdata 0xDEADBEEF.
REQ-034 Then write 0x8 wdata 0x11223344 be=0101; read 0x8 -> rdata 0xDE22BE44.
REQ-035 MEM_DEPTH=16: read 0x40 -> err=1, rdata 0; write 0x6 -> err=1; word 1 unchanged.
REQ-036 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and rdata stable, req_ready=0 throughout; accepted on the cycle resp_ready=1.
REQ-037 Assert reset during WAIT -> resp_valid never rises for that request; init_busy=1 next cycle; full INIT repeats.
